// File: rtl/riscv_instr_encoder.sv
// RV32IM instruction encoder: turns field-level requests into 32-bit words,
// expands LI into LUI/ADDI, and queues the results in a small output FIFO.
module riscv_instr_encoder #(
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_DIV = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_class,
  input  logic [2:0]  req_funct3,
  input  logic        req_alt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        err_illegal,
  output logic [31:0] instr_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    CL_LUI = 4'd0, CL_AUIPC = 4'd1, CL_JAL = 4'd2, CL_JALR = 4'd3,
    CL_BRANCH = 4'd4, CL_LOAD = 4'd5, CL_STORE = 4'd6, CL_IMM = 4'd7,
    CL_REG = 4'd8, CL_MDU = 4'd9, CL_LI = 4'd10
  } class_t;

  typedef enum logic {S_IDLE, S_LI_LO} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [4:0]        li_rd;
  logic [11:0]       li_lo;

  logic              accept, pop, push, legal, need_lo, alt_ok;
  logic              fits12, fits13, fits21;
  logic [6:0]        funct7;
  logic [19:0]       li_hi;
  logic [31:0]       word, push_word;

  assign req_ready   = (state == S_IDLE) && (count <= READY_MAX);
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem[rd_ptr] : '0;
  assign accept      = req_valid && req_ready;
  assign pop         = instr_valid && instr_ready;

  assign fits12 = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
  assign fits13 = (req_imm[31:12] == '0) || (req_imm[31:12] == '1);
  assign fits21 = (req_imm[31:20] == '0) || (req_imm[31:20] == '1);
  // Rounding the upper part up when bit 11 is set compensates for ADDI sign-extension.
  assign li_hi  = req_imm[31:12] + 20'(req_imm[11]);

  always_comb begin
    word    = '0;
    legal   = 1'b0;
    need_lo = 1'b0;
    funct7  = req_alt ? 7'b0100000 : 7'b0000000;
    alt_ok  = !req_alt
           || (req_class == CL_REG && (req_funct3 == 3'b000 || req_funct3 == 3'b101))
           || (req_class == CL_IMM && req_funct3 == 3'b101);
    case (req_class)
      CL_LUI: begin
        legal = 1'b1;
        word  = {req_imm[31:12], req_rd, OP_LUI};
      end
      CL_AUIPC: begin
        legal = 1'b1;
        word  = {req_imm[31:12], req_rd, OP_AUIPC};
      end
      CL_JAL: begin
        legal = fits21 && !req_imm[0];
        word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      end
      CL_JALR: begin
        legal = (req_funct3 == 3'b000) && fits12;
        word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      CL_BRANCH: begin
        legal = (req_funct3 != 3'b010) && (req_funct3 != 3'b011) && fits13 && !req_imm[0];
        word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                 req_imm[4:1], req_imm[11], OP_BRANCH};
      end
      CL_LOAD: begin
        legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && fits12;
        word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
      end
      CL_STORE: begin
        legal = (req_funct3 <= 3'b010) && fits12;
        word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      end
      CL_IMM: begin
        if (req_funct3[1:0] == 2'b01) begin
          legal = (req_imm[31:5] == '0);
          word  = {funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_IMM};
        end else begin
          legal = fits12;
          word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IMM};
        end
      end
      CL_REG: begin
        legal = 1'b1;
        word  = {funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_REG};
      end
      CL_MDU: begin
        legal = req_funct3[2] ? ENABLE_DIV : ENABLE_MUL;
        word  = {7'b0000001, req_rs2, req_rs1, req_funct3, req_rd, OP_REG};
      end
      CL_LI: begin
        legal = 1'b1;
        if (fits12) begin
          word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
        end else begin
          word    = {li_hi, req_rd, OP_LUI};
          need_lo = (req_imm[11:0] != '0);
        end
      end
      default: legal = 1'b0;
    endcase
    legal = legal && alt_ok;
  end

  // Next-state and FIFO write selection; the ADDI half of LI always fits
  // because acceptance required two free entries.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_word = word;
    case (state)
      S_IDLE: begin
        if (accept && legal) begin
          push = 1'b1;
          if (need_lo) state_nxt = S_LI_LO;
        end
      end
      S_LI_LO: begin
        push      = 1'b1;
        push_word = {li_lo, li_rd, 3'b000, li_rd, OP_IMM};
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      li_rd       <= '0;
      li_lo       <= '0;
      err_illegal <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      err_illegal <= accept && !legal;
      if (accept) begin
        li_rd <= req_rd;
        li_lo <= req_imm[11:0];
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        instr_count <= instr_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed bench for riscv_instr_encoder: vector table of single-word requests
// plus hand sequences for LI expansion, FIFO backpressure and reset mid-LI.
module tb_riscv_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_class = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_alt = 1'b0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic        err_illegal;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  riscv_instr_encoder #(
    .ENABLE_MUL(1'b1),
    .ENABLE_DIV(1'b0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_funct3(req_funct3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .err_illegal(err_illegal), .instr_count(instr_count)
  );

  typedef struct {
    string       name;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count = '0;

  function automatic void addVec(string name, logic [3:0] cls, logic [2:0] f3, logic alt,
                                 logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [31:0] imm, logic legal, logic [31:0] word);
    vec_t v;
    v.name = name; v.cls = cls; v.f3 = f3; v.alt = alt;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.legal = legal; v.word = word;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
    req_class = cls; req_funct3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
  endtask

  // LI expansion with the consumer always ready: LUI then (optionally) ADDI on consecutive cycles
  task automatic runLi(input string name, input logic [4:0] rd, input logic [31:0] v,
                       input logic [31:0] hi_word, input logic has_lo, input logic [31:0] lo_word);
    applyStimulus(4'd10, 3'b000, 1'b0, rd, 5'd0, 5'd0, v);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    checkOutput({name, "_first"}, instr, hi_word);
    checkOutput({name, "_ready_n1"}, 32'(req_ready), has_lo ? 32'd0 : 32'd1);
    exp_count++;
    @(negedge clk);
    if (has_lo) begin
      checkOutput({name, "_second"}, instr, lo_word);
      checkOutput({name, "_second_valid"}, 32'(instr_valid), 32'd1);
      exp_count++;
      @(negedge clk);
    end
    checkOutput({name, "_drained"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] stream_words [3];
    logic [31:0] exp_q[$];
    int          idx;
    int          pops;
    logic        accepted;

    stream_words[0] = 32'h06400093;
    stream_words[1] = 32'h06500093;
    stream_words[2] = 32'h06600093;

    addVec("addi",      4'd7,  3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'd5,        1'b1, 32'h00500093);
    addVec("sub",       4'd8,  3'b000, 1'b1, 5'd3,  5'd1,  5'd2,  32'd0,        1'b1, 32'h402081B3);
    addVec("div_off",   4'd9,  3'b100, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0,        1'b0, 32'h0);
    addVec("mul",       4'd9,  3'b000, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0,        1'b1, 32'h02C58533);
    addVec("br_odd",    4'd4,  3'b000, 1'b0, 5'd0,  5'd1,  5'd2,  32'd3,        1'b0, 32'h0);
    addVec("jal_range", 4'd2,  3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00100000, 1'b0, 32'h0);
    addVec("lui",       4'd0,  3'b000, 1'b0, 5'd5,  5'd0,  5'd0,  32'h12345678, 1'b1, 32'h123452B7);
    addVec("jal",       4'd2,  3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'd8,        1'b1, 32'h008000EF);
    addVec("beq_neg",   4'd4,  3'b000, 1'b0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
    addVec("bne_min",   4'd4,  3'b001, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFFF000, 1'b1, 32'h80001063);
    addVec("br_f3_010", 4'd4,  3'b010, 1'b0, 5'd0,  5'd1,  5'd2,  32'd4,        1'b0, 32'h0);
    addVec("lw",        4'd5,  3'b010, 1'b0, 5'd6,  5'd2,  5'd0,  32'hFFFFFFF8, 1'b1, 32'hFF812303);
    addVec("ld_f3_011", 4'd5,  3'b011, 1'b0, 5'd6,  5'd2,  5'd0,  32'd0,        1'b0, 32'h0);
    addVec("sw",        4'd6,  3'b010, 1'b0, 5'd0,  5'd2,  5'd5,  32'd12,       1'b1, 32'h00512623);
    addVec("srai",      4'd7,  3'b101, 1'b1, 5'd7,  5'd7,  5'd0,  32'd3,        1'b1, 32'h4033D393);
    addVec("slli_big",  4'd7,  3'b001, 1'b0, 5'd7,  5'd7,  5'd0,  32'd32,       1'b0, 32'h0);
    addVec("jalr",      4'd3,  3'b000, 1'b0, 5'd0,  5'd1,  5'd0,  32'd0,        1'b1, 32'h00008067);
    addVec("jalr_f3",   4'd3,  3'b001, 1'b0, 5'd0,  5'd1,  5'd0,  32'd0,        1'b0, 32'h0);
    addVec("addi_2048", 4'd7,  3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000800, 1'b0, 32'h0);
    addVec("addi_min",  4'd7,  3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFFF800, 1'b1, 32'h80000093);
    addVec("sll_alt",   4'd8,  3'b001, 1'b1, 5'd3,  5'd1,  5'd2,  32'd0,        1'b0, 32'h0);
    addVec("class11",   4'd11, 3'b000, 1'b0, 5'd1,  5'd1,  5'd1,  32'd0,        1'b0, 32'h0);
    addVec("auipc",     4'd1,  3'b000, 1'b0, 5'd3,  5'd0,  5'd0,  32'hFFFFF123, 1'b1, 32'hFFFFF197);
    addVec("li_small",  4'd10, 3'b000, 1'b0, 5'd4,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b1, 32'hFFF00213);
    addVec("li_lui",    4'd10, 3'b000, 1'b0, 5'd2,  5'd0,  5'd0,  32'h00003000, 1'b1, 32'h00003137);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_err", 32'(err_illegal), 32'd0);
    checkOutput("rst_count", instr_count, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      checkOutput({vecs[i].name, "_ready"}, 32'(req_ready), 32'd1);
      applyStimulus(vecs[i].cls, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1,
                    vecs[i].rs2, vecs[i].imm);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      if (vecs[i].legal) begin
        checkOutput({vecs[i].name, "_word"}, instr, vecs[i].word);
        checkOutput({vecs[i].name, "_valid"}, 32'(instr_valid), 32'd1);
        checkOutput({vecs[i].name, "_err"}, 32'(err_illegal), 32'd0);
        exp_count++;
      end else begin
        checkOutput({vecs[i].name, "_err"}, 32'(err_illegal), 32'd1);
        checkOutput({vecs[i].name, "_valid"}, 32'(instr_valid), 32'd0);
      end
      @(negedge clk);
      checkOutput({vecs[i].name, "_idle"}, {30'd0, instr_valid, err_illegal}, 32'd0);
    end
    checkOutput("count_table", instr_count, exp_count);

    runLi("li_big", 5'd5, 32'h12345678, 32'h123452B7, 1'b1, 32'h67828293);
    runLi("li_fff", 5'd1, 32'h00000FFF, 32'h000010B7, 1'b1, 32'hFFF08093);
    runLi("li_3000", 5'd2, 32'h00003000, 32'h00003137, 1'b0, 32'h0);
    checkOutput("count_li", instr_count, exp_count);

    // Backpressure: with the consumer stalled only three requests fit
    instr_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(100 + idx));
      accepted = req_ready;
      @(posedge clk);
      if (accepted) begin
        if (idx < 3) exp_q.push_back(stream_words[idx]);
        idx++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("stream_accepted", 32'(idx), 32'd3);
    checkOutput("stream_ready_full", 32'(req_ready), 32'd0);
    instr_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      if (instr_valid) begin
        if (exp_q.size() > 0) checkOutput("stream_word", instr, exp_q.pop_front());
        else checkOutput("stream_extra_word", 32'(instr_valid), 32'd0);
        pops++;
      end
      @(negedge clk);
    end
    checkOutput("stream_pops", 32'(pops), 32'd3);
    exp_count += 32'd3;
    checkOutput("count_stream", instr_count, exp_count);

    // Reset while the ADDI half of an LI is pending
    instr_ready = 1'b0;
    applyStimulus(4'd10, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midli_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midli_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midli_rst_instr", instr, 32'd0);
    checkOutput("midli_rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midli_no_addi", 32'(instr_valid), 32'd0);
      checkOutput("midli_ready_after", 32'(req_ready), 32'd1);
    end
    checkOutput("midli_count_after", instr_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_instr_encoder.md
Name: riscv_instr_encoder

Overview:
Inverse of the single-cycle core's control decoder: encodes field-level instruction requests (class, funct3, register indices, immediate) into RV32IM 32-bit instruction words. Feeds the core's instruction-memory loader and the self-test program generator. Expands the LI pseudo-op into LUI and ADDI through a small state machine. Buffers output words in a FIFO with valid/ready handshakes on both sides.

Parameters:
ENABLE_MUL, 1, MDU requests with funct3[2]=0 are legal
ENABLE_DIV, 1, MDU requests with funct3[2]=1 are legal
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid&&req_ready
req_class  input  4  0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 IMM,8 REG,9 MDU,10 LI; 11-15 illegal
req_funct3  input  3  funct3 field; ignored for LUI/AUIPC/JAL/LI; must be 000 for JALR
req_alt  input  1  selects funct7=0100000 (SUB/SRA/SRAI)
req_rd, req_rs1, req_rs2  input  5 each  register indices
req_imm  input  32  immediate, byte-offset value (not pre-shifted)
instr_valid  output  1  FIFO not empty
instr_ready  input  1  consumer takes word when instr_valid&&instr_ready
instr  output  32  FIFO head word
err_illegal  output  1  one-cycle pulse: accepted request rejected, no word emitted
instr_count  output  32  words consumed at output, wraps 2^32-1 -> 0

Behaviour:
- Reset (async, rst_n low): FIFO empty, instr_valid=0, instr=0, err_illegal=0, instr_count=0, FSM=IDLE.
- req_ready = (FSM==IDLE) && (free FIFO entries >= 2), from registered state only; no combinational path from req_valid or instr_ready.
- Latency: request accepted in cycle N -> word at FIFO head, instr_valid=1 in cycle N+1 (if FIFO was empty).
- Immediate legality: I/S 12-bit signed; B 13-bit signed, imm[0]=0; J 21-bit signed, imm[0]=0; U uses imm[31:12], imm[11:0] ignored; shift-immediate (IMM, funct3 001/101) requires imm[31:5]=0.
- Field legality: BRANCH funct3 not in {010,011}; LOAD funct3 in {000,001,010,100,101}; STORE funct3 in {000,001,010}; JALR funct3=000; req_alt only allowed for REG funct3 000/101 and IMM funct3 101; MDU gated by ENABLE_MUL/ENABLE_DIV per funct3[2].
- Illegal request: still accepted (handshake completes), nothing written, err_illegal=1 in cycle N+1 only.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, IMM 0010011, REG/MDU 0110011; MDU funct7=0000001.
- LI (class 10), value V: if V fits 12-bit signed -> one word ADDI rd,x0,V[11:0]. Else hi=(V+0x800)>>12 (mod 2^20); cycle N+1 writes LUI rd,hi; if V[11:0]!=0, FSM enters LI_LO, cycle N+2 writes ADDI rd,rd,V[11:0], FSM returns to IDLE. req_ready=0 while in LI_LO.
- FIFO: simultaneous push and pop allowed at any occupancy, including full; FIFO never overflows, guaranteed by the 2-free-entry rule. Pointers wrap modulo FIFO_DEPTH.
- instr_count increments only on output handshake.
- Reset asserted mid-LI (FSM=LI_LO): FSM->IDLE, FIFO flushed, pending ADDI never emitted.

Test Plan:
- IMM f3=000 rd=1 rs1=0 imm=5 -> instr=0x00500093 at cycle N+1; instr_count=1 after pop.
- REG f3=000 alt=1 rd=3 rs1=1 rs2=2 -> 0x402081B3. MDU f3=100 with ENABLE_DIV=0 -> err_illegal pulse in cycle N+1, FIFO stays empty.
- LI rd=5 V=0x12345678 -> 0x123452B7 then 0x67828293 on consecutive cycles; req_ready=0 during LI_LO. LI rd=1 V=0xFFF -> 0x000010B7, 0xFFF08093. LI rd=2 V=0x3000 -> LUI only, 0x00003137.
- BRANCH imm=3 (odd) -> err_illegal, nothing emitted. JAL imm=0x100000 (out of 21-bit range) -> err_illegal, nothing emitted.
- instr_ready=0, FIFO_DEPTH=4, stream ADDIs -> 3 accepted, then req_ready=0. Release instr_ready -> words popped in order, no loss or duplication.
- rst_n low during LI_LO -> instr_valid=0 immediately, count=0; ADDI half never appears after reset release.
